// File: rtl/intc_ext.sv
`default_nettype none
// ============================================================================
// Module      : intc_ext
// Description : External interrupt controller feeding cop0's external-interrupt
//               request. Edge/level pending latch, mask, fixed-priority select,
//               exception-taken acknowledge and eret end-of-service.
//               Optional 2-flop input synchroniser: define INTC_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module intc_ext #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_we,
    input  logic [1:0]         i_addr,
    input  logic [31:0]        i_data,
    output logic [31:0]        o_data,
    input  logic               i_exception,
    input  logic               i_eret,
    output logic               o_ext_int,
    output logic [ID_W-1:0]    o_irq_id
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_edge;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_w1c;
    logic [ID_W-1:0]    w_sel;
    logic [ID_W-1:0]    r_irq_id;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_any;
    logic               w_ack;
    logic               w_unused;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_src;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_rise   = w_s & ~r_prev;
    assign w_active = r_pend & r_mask;
    assign w_any    = |w_active;
    assign w_w1c    = (i_we && (i_addr == 2'd1)) ? i_data[NUM_SRC-1:0] : '0;
    assign w_ack    = (r_state == ST_REQ) && i_exception && w_any;
    assign w_unused = ^i_data;

    // Descending scan so the lowest active index is the last (winning) write.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    // Edge mode: a fresh rising edge beats any clear arriving in the same cycle.
    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_pend
            assign w_pend_nxt[g] = r_edge[g]
                ? (w_rise[g] | (r_pend[g] & ~(w_w1c[g] | (w_ack && (w_sel == ID_W'(g))))))
                : w_s[g];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
            r_edge <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (i_we && (i_addr == 2'd0)) begin
                r_mask <= i_data[NUM_SRC-1:0];
            end
            if (i_we && (i_addr == 2'd2)) begin
                r_edge <= i_data[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_irq_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ack) begin
                r_irq_id <= w_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_exception) begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (i_eret) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_data = '0;
        case (i_addr)
            2'd0: o_data[NUM_SRC-1:0] = r_mask;
            2'd1: o_data[NUM_SRC-1:0] = r_pend;
            2'd2: o_data[NUM_SRC-1:0] = r_edge;
            default: begin
                o_data[9:8]      = r_state;
                o_data[ID_W-1:0] = r_irq_id;
            end
        endcase
    end

    assign o_ext_int = (r_state == ST_REQ);
    assign o_irq_id  = r_irq_id;

endmodule
`default_nettype wire

// File: doc/intc_ext.md
Name: intc_ext

Overview:
- External interrupt controller that sits in front of cop0 and drives its external-interrupt request line.
- Collects NUM_SRC peripheral interrupt lines and latches them as pending, either edge- or level-triggered per source.
- Masks and priority-encodes the pending lines, then raises o_ext_int toward cop0.
- Treats cop0's exception-taken pulse as the acknowledge and cop0's eret as end-of-service.
- Registers are read and written through a small word-addressed port driven by mtc0/mfc0-style or MMIO logic.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32); source 0 has the highest priority.
- ID_W, 5, width of the interrupt ID field; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_src  input  NUM_SRC  raw interrupt lines from peripherals.
- i_we  input  1  register write strobe.
- i_addr  input  2  register select.
- i_data  input  32  write data.
- o_data  output  32  read data, combinational from i_addr.
- i_exception  input  1  cop0 exception-taken pulse (acknowledge).
- i_eret  input  1  cop0 eret, end of service.
- o_ext_int  output  1  interrupt request to cop0.
- o_irq_id  output  ID_W  ID of the source being serviced.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high on i_rst, sampled on the rising edge of i_clk.
  - Reset values: mask=0, pending=0, edge=0, all sync and previous-value flops=0, state=IDLE, o_ext_int=0, o_irq_id=0.
  - Reset asserted mid-service drops o_ext_int the cycle after the reset edge and discards all pending state.
- Register map:
  - addr 0, MASK, RW: bit i=1 enables source i.
  - addr 1, PENDING, R/W1C. W1C acts only on edge-mode bits.
  - addr 2, EDGE, RW: bit i=1 selects edge mode for source i, 0 selects level mode.
  - addr 3, STATUS, RO: [9:8]=state (IDLE=0, REQ=1, SERVICE=2); [ID_W-1:0]=o_irq_id; all other bits 0.
  - Writes to addr 3 are ignored.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Input conditioning: s = synchronised i_src (see the Optional Feature); p = s delayed one cycle.
- Pending update, edge-mode bit:
  - Set when s & ~p.
  - Cleared by W1C, or by acknowledge of that ID.
  - Set and clear in the same cycle: set wins.
- Pending update, level-mode bit: pending follows s every cycle; W1C and acknowledge have no effect.
- Request logic: active = pending & mask. sel = lowest index set in active.
- State machine (o_ext_int = 1 only in REQ):
  - IDLE -> REQ when |active.
  - REQ -> IDLE when active == 0 (masked or cleared before acknowledge).
  - REQ -> SERVICE when i_exception. On this edge:
    - o_irq_id <= sel;
    - if source sel is in edge mode, its pending bit clears, unless a new edge arrives in the same cycle.
  - If i_exception and active == 0 in the same cycle: IDLE, no ID latched.
  - SERVICE -> IDLE on i_eret; o_irq_id holds its value.
  - i_exception outside REQ and i_eret outside SERVICE are ignored.
  - No nesting: new pending bits accumulate during SERVICE, and REQ re-enters one cycle after IDLE if |active.
- Latency, with sync: source rises before edge E0 -> stage1 at E0, s at E1, pending at E2, o_ext_int high after E3.

Optional Feature:
- Macro: INTC_SYNC_EN.
- Defined: i_src passes through a 2-flop synchroniser to form s (latency as stated above).
- Undefined: s = i_src directly. Pending sets on the edge where i_src is first sampled high, and o_ext_int is high one cycle later.
- p and the edge-detect logic are identical in both builds.

Test Plan:
- Reset, then read addr 0..3 -> all 0x00000000; o_ext_int=0.
- MASK=0x01, EDGE=0x01, pulse i_src[0] for one cycle -> PENDING=0x01, o_ext_int high 3 cycles after first sample (1 without INTC_SYNC_EN); i_exception -> o_irq_id=0, PENDING=0x00, STATUS[9:8]=2; i_eret -> STATUS[9:8]=0.
- MASK=0xFF, EDGE=0xFF, pulse sources 5 and 2 together -> acknowledge gives o_irq_id=2, PENDING=0x20; after i_eret, REQ re-enters and the second acknowledge gives o_irq_id=5.
- Level source 3 (EDGE=0, MASK=0x08) held high -> stays PENDING=0x08 through W1C write 0x08 and through acknowledge; drop i_src[3] during SERVICE, then i_eret -> IDLE, o_ext_int stays 0.
- In REQ on edge source 1, write MASK=0 -> IDLE next cycle, o_ext_int=0, PENDING still 0x02; W1C 0x02 in the same cycle as a new edge on source 1 -> PENDING=0x02.
- Assert i_rst during SERVICE -> next cycle all registers 0, o_ext_int=0, o_irq_id=0; i_eret afterwards has no effect.
